// File: rtl/srv_mem_pkg.sv
// Shared types and constants for the line-fill responder.
// Prefetch states exist only when SRV_LINE_FILL_PREFETCH_EN is defined.
package srv_mem_pkg;

    localparam int LINE_WORDS = 4;
    localparam int LINE_BITS  = 128;
    localparam int OFFS_W     = 4;
    localparam int BASE_W     = 32 - OFFS_W;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT    = 3'd1,
        ST_FILL    = 3'd2,
        ST_RESP    = 3'd3,
        ST_DONE    = 3'd4
`ifdef SRV_LINE_FILL_PREFETCH_EN
        ,
        ST_PF_WAIT = 3'd5,
        ST_PF_FILL = 3'd6
`endif
    } state_e;

endpackage

// File: rtl/srv_line_fill_resp_if.sv
// Line-fill request/response bundle between the I-cache and the responder.
interface srv_line_fill_resp_if;
    import srv_mem_pkg::*;

    logic                 ext_req_i;
    logic [31:0]          ext_addr_i;
    logic                 ext_rsp_o;
    logic [LINE_BITS-1:0] ext_data_o;

    modport master (
        output ext_req_i,
        output ext_addr_i,
        input  ext_rsp_o,
        input  ext_data_o
    );

    modport slave (
        input  ext_req_i,
        input  ext_addr_i,
        output ext_rsp_o,
        output ext_data_o
    );

endinterface

// File: rtl/srv_line_buf.sv
// 4x32 line assembler: writes one word slot per cycle or loads a whole line.
module srv_line_buf
    import srv_mem_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we_i,
    input  logic [1:0]           idx_i,
    input  logic [31:0]          wdata_i,
    input  logic                 ld_i,
    input  logic [LINE_BITS-1:0] ld_line_i,
    output logic [LINE_BITS-1:0] line_o
);

    logic [LINE_BITS-1:0] line_q, line_d;

    always_comb begin
        line_d = line_q;
        if (ld_i)
            line_d = ld_line_i;
        else if (we_i)
            line_d[{idx_i, 5'd0} +: 32] = wdata_i;
    end

    always_ff @(posedge clk) begin
        if (rst)
            line_q <= '0;
        else
            line_q <= line_d;
    end

    assign line_o = line_q;

endmodule

// File: rtl/srv_line_fill_resp.sv
// Line-fill responder: reads four ROM words per request after WAIT_CYCLES idle cycles.
// SRV_LINE_FILL_PREFETCH_EN adds a single next-line prefetch buffer.
module srv_line_fill_resp
    import srv_mem_pkg::*;
#(
    parameter int WAIT_CYCLES = 0,
    parameter int WCNT_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    srv_line_fill_resp_if.slave  ext,
    output logic [31:0]          rom_addr_o,
    input  logic [31:0]          rom_data_i
);

    localparam bit HAS_WAIT = (WAIT_CYCLES > 0);
    localparam logic [WCNT_W-1:0] WLAST = WCNT_W'(WAIT_CYCLES - 1);

    state_e              state_q, state_d;
    logic [BASE_W-1:0]   base_q, base_d;
    logic [1:0]          k_q, k_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic                rsp_q, rsp_d;
    logic [31:0]         rom_addr_q, rom_addr_d;
    logic                buf_we, buf_ld, accept;
    logic [LINE_BITS-1:0] ld_line, line;

`ifdef SRV_LINE_FILL_PREFETCH_EN
    logic [BASE_W-1:0]   pf_tag_q, pf_tag_d;
    logic                pf_vld_q, pf_vld_d;
    logic                pf_pend_q, pf_pend_d;
    logic                pf_we;
    logic [LINE_BITS-1:0] pf_line;
`endif

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        k_d        = k_q;
        wcnt_d     = wcnt_q;
        rsp_d      = 1'b0;
        rom_addr_d = rom_addr_q;
        buf_we     = 1'b0;
        buf_ld     = 1'b0;
        accept     = 1'b0;
`ifdef SRV_LINE_FILL_PREFETCH_EN
        pf_tag_d   = pf_tag_q;
        pf_vld_d   = pf_vld_q;
        pf_pend_d  = pf_pend_q;
        pf_we      = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE: begin
`ifdef SRV_LINE_FILL_PREFETCH_EN
                if (ext.ext_req_i) begin
                    if (pf_vld_q && pf_tag_q == ext.ext_addr_i[31:OFFS_W]) begin
                        base_d  = ext.ext_addr_i[31:OFFS_W];
                        buf_ld  = 1'b1;
                        rsp_d   = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        accept   = 1'b1;
                        pf_vld_d = 1'b0;
                    end
                end else if (pf_pend_q) begin
                    // Speculatively fetch the line after the last one served.
                    pf_pend_d = 1'b0;
                    pf_vld_d  = 1'b0;
                    pf_tag_d  = base_q + BASE_W'(1);
                    k_d       = 2'd0;
                    wcnt_d    = '0;
                    if (HAS_WAIT) begin
                        state_d = ST_PF_WAIT;
                    end else begin
                        state_d    = ST_PF_FILL;
                        rom_addr_d = {base_q + BASE_W'(1), 2'd0};
                    end
                end
`else
                accept = ext.ext_req_i;
`endif
            end
            ST_WAIT: begin
                if (wcnt_q == WLAST) begin
                    state_d    = ST_FILL;
                    rom_addr_d = {base_q, 2'd0};
                end else begin
                    wcnt_d = wcnt_q + WCNT_W'(1);
                end
            end
            ST_FILL: begin
                buf_we = 1'b1;
                k_d    = k_q + 2'd1;
                if (k_q == 2'd3) begin
                    state_d = ST_RESP;
                    rsp_d   = 1'b1;
                end else begin
                    rom_addr_d = {base_q, k_q + 2'd1};
                end
            end
            ST_RESP: state_d = ST_DONE;
            ST_DONE: begin
                // A request still high here belongs to the line just served.
                if (!ext.ext_req_i) begin
                    state_d = ST_IDLE;
`ifdef SRV_LINE_FILL_PREFETCH_EN
                    pf_pend_d = 1'b1;
`endif
                end
            end
`ifdef SRV_LINE_FILL_PREFETCH_EN
            ST_PF_WAIT: begin
                if (ext.ext_req_i) begin
                    accept   = 1'b1;
                    pf_vld_d = 1'b0;
                end else if (wcnt_q == WLAST) begin
                    state_d    = ST_PF_FILL;
                    rom_addr_d = {pf_tag_q, 2'd0};
                end else begin
                    wcnt_d = wcnt_q + WCNT_W'(1);
                end
            end
            ST_PF_FILL: begin
                if (ext.ext_req_i) begin
                    accept   = 1'b1;
                    pf_vld_d = 1'b0;
                end else begin
                    pf_we = 1'b1;
                    k_d   = k_q + 2'd1;
                    if (k_q == 2'd3) begin
                        pf_vld_d = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        rom_addr_d = {pf_tag_q, k_q + 2'd1};
                    end
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        if (accept) begin
            base_d = ext.ext_addr_i[31:OFFS_W];
            k_d    = 2'd0;
            wcnt_d = '0;
            if (HAS_WAIT) begin
                state_d = ST_WAIT;
            end else begin
                state_d    = ST_FILL;
                rom_addr_d = {ext.ext_addr_i[31:OFFS_W], 2'd0};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            base_q     <= '0;
            k_q        <= '0;
            wcnt_q     <= '0;
            rsp_q      <= 1'b0;
            rom_addr_q <= '0;
`ifdef SRV_LINE_FILL_PREFETCH_EN
            pf_tag_q   <= '0;
            pf_vld_q   <= 1'b0;
            pf_pend_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            k_q        <= k_d;
            wcnt_q     <= wcnt_d;
            rsp_q      <= rsp_d;
            rom_addr_q <= rom_addr_d;
`ifdef SRV_LINE_FILL_PREFETCH_EN
            pf_tag_q   <= pf_tag_d;
            pf_vld_q   <= pf_vld_d;
            pf_pend_q  <= pf_pend_d;
`endif
        end
    end

`ifdef SRV_LINE_FILL_PREFETCH_EN
    srv_line_buf u_pf_buf (
        .clk       (clk),
        .rst       (rst),
        .we_i      (pf_we),
        .idx_i     (k_q),
        .wdata_i   (rom_data_i),
        .ld_i      (1'b0),
        .ld_line_i ('0),
        .line_o    (pf_line)
    );
    assign ld_line = pf_line;
`else
    assign ld_line = '0;
`endif

    srv_line_buf u_ext_buf (
        .clk       (clk),
        .rst       (rst),
        .we_i      (buf_we),
        .idx_i     (k_q),
        .wdata_i   (rom_data_i),
        .ld_i      (buf_ld),
        .ld_line_i (ld_line),
        .line_o    (line)
    );

    assign ext.ext_rsp_o  = rsp_q;
    assign ext.ext_data_o = line;
    assign rom_addr_o     = rom_addr_q;

endmodule

// File: tb/tb_srv_line_fill_resp.sv
// Bench for srv_line_fill_resp: two instances (0 and 3 wait states), table + random.
module tb_srv_line_fill_resp;
    import srv_mem_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    srv_line_fill_resp_if if0();
    srv_line_fill_resp_if if3();

    logic [31:0] ra0, ra3, rd0, rd3;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return 32'hA000_0000 + a;
    endfunction

    function automatic logic [127:0] line_of(input logic [27:0] b);
        logic [127:0] l;
        for (int k = 0; k < 4; k++) l[32*k +: 32] = rom({b, 2'(k)});
        return l;
    endfunction

    assign rd0 = rom(ra0);
    assign rd3 = rom(ra3);

    srv_line_fill_resp #(.WAIT_CYCLES(0), .WCNT_W(8)) d0 (
        .clk(clk), .rst(rst), .ext(if0.slave),
        .rom_addr_o(ra0), .rom_data_i(rd0)
    );
    srv_line_fill_resp #(.WAIT_CYCLES(3), .WCNT_W(8)) d3 (
        .clk(clk), .rst(rst), .ext(if3.slave),
        .rom_addr_o(ra3), .rom_data_i(rd3)
    );

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic logic g_rsp(input bit s);
        return s ? if3.ext_rsp_o : if0.ext_rsp_o;
    endfunction
    function automatic logic [127:0] g_data(input bit s);
        return s ? if3.ext_data_o : if0.ext_data_o;
    endfunction
    function automatic logic [31:0] g_ra(input bit s);
        return s ? ra3 : ra0;
    endfunction

    task automatic drv(input bit s, input logic r, input logic [31:0] a);
        if (s) begin
            if3.ext_req_i = r; if3.ext_addr_i = a;
        end else begin
            if0.ext_req_i = r; if0.ext_addr_i = a;
        end
    endtask

    task automatic do_rst();
        @(posedge clk); #1;
        rst = 1'b1; drv(0, 0, 0); drv(1, 0, 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Cycle 0 is the cycle whose closing edge first sees the request.
    task automatic do_req(input bit s, input logic [31:0] a, input int hold, input bit scr,
                          output int lat, output logic [127:0] d,
                          output int np, output bit rok);
        int w;
        w = s ? 3 : 0;
        lat = -1; d = '0; np = 0; rok = 1'b1;
        @(posedge clk); #1;
        drv(s, 1, a);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (g_rsp(s)) begin
                np++;
                if (lat < 0) begin lat = c; d = g_data(s); end
            end
            if (c >= w + 1 && c <= w + 4 && g_ra(s) !== {a[31:4], 2'(c - w - 1)})
                rok = 1'b0;
            if (lat >= 0 && c >= lat + hold) break;
            @(posedge clk); #1;
            if (scr) drv(s, 1, $urandom);
        end
        @(posedge clk); #1;
        drv(s, 0, $urandom);
    endtask

    typedef struct {
        bit           s;
        logic [31:0]  a;
        int           hold;
        int           lat;
        logic [127:0] d;
    } vec_t;

    vec_t tv[6];

    initial begin
        int lat, np;
        logic [127:0] d;
        bit rok, s, pf;
        logic [31:0] a;
        logic [27:0] prv[2];
        int w;

`ifdef SRV_LINE_FILL_PREFETCH_EN
        pf = 1'b1;
`else
        pf = 1'b0;
`endif
        tv[0] = '{0, 32'h0000_0010, 0, 5, 128'hA0000007_A0000006_A0000005_A0000004};
        tv[1] = '{1, 32'h0000_002C, 0, 8, 128'hA000000B_A000000A_A0000009_A0000008};
        tv[2] = '{0, 32'h0000_0000, 4, 5, 128'hA0000003_A0000002_A0000001_A0000000};
        tv[3] = '{0, 32'h0000_0100, 0, 5, 128'hA0000043_A0000042_A0000041_A0000040};
        tv[4] = '{0, 32'hFFFF_FFF8, 0, 5, line_of(28'hFFF_FFFF)};
        tv[5] = '{1, 32'h1234_567F, 2, 8, line_of(28'h123_4567)};

        drv(0, 0, 0); drv(1, 0, 0);
        do_rst();
        @(negedge clk);
        chk("rst_rsp0", if0.ext_rsp_o, 0);
        chk("rst_data0", if0.ext_data_o, 0);
        chk("rst_rom0", ra0, 0);
        chk("rst_rsp3", if3.ext_rsp_o, 0);
        chk("rst_data3", if3.ext_data_o, 0);

        for (int i = 0; i < 6; i++) begin
            do_req(tv[i].s, tv[i].a, tv[i].hold, 1'b0, lat, d, np, rok);
            chk($sformatf("tv%0d_lat", i), lat, tv[i].lat);
            chk($sformatf("tv%0d_data", i), d, tv[i].d);
            chk($sformatf("tv%0d_pulses", i), np, 1);
            chk($sformatf("tv%0d_romseq", i), rok, 1);
            prv[tv[i].s] = tv[i].a[31:4];
        end

        // Reset asserted in cycle 2 of a fill.
        @(posedge clk); #1;
        drv(0, 1, 32'h40);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1; drv(0, 0, 0); drv(1, 0, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        np = 0;
        repeat (8) begin
            @(negedge clk);
            if (if0.ext_rsp_o) np++;
        end
        chk("midrst_pulses", np, 0);
        chk("midrst_data", if0.ext_data_o, 0);
        chk("midrst_rom", ra0, 0);
        do_req(0, 32'h50, 0, 1'b0, lat, d, np, rok);
        chk("postrst_lat", lat, 5);
        chk("postrst_data", d, line_of(28'h5));
        prv[0] = 28'h5;
        prv[1] = 28'h0;

        for (int i = 0; i < 40; i++) begin
            s = 1'($urandom_range(0, 1));
            w = s ? 3 : 0;
            a = $urandom;
            if ($urandom_range(0, 3) == 0) a[31:4] = prv[s] + 28'd1;
            do_req(s, a, $urandom_range(0, 3), 1'b1, lat, d, np, rok);
            if (pf && lat == 1 && a[31:4] == prv[s] + 28'd1)
                chk("rnd_lat", lat, 1);
            else
                chk("rnd_lat", lat, 5 + w);
            chk("rnd_data", d, line_of(a[31:4]));
            chk("rnd_pulses", np, 1);
            if (lat == 5 + w) chk("rnd_romseq", rok, 1);
            prv[s] = a[31:4];
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

`ifdef SRV_LINE_FILL_PREFETCH_EN
        do_rst();
        do_req(0, 32'h0, 0, 1'b0, lat, d, np, rok);
        repeat (10) @(posedge clk);
        do_req(0, 32'h10, 0, 1'b0, lat, d, np, rok);
        chk("pf_hit_lat", lat, 1);
        chk("pf_hit_data", d, line_of(28'h1));
        do_rst();
        do_req(0, 32'h0, 0, 1'b0, lat, d, np, rok);
        @(posedge clk);
        do_req(0, 32'h10, 0, 1'b0, lat, d, np, rok);
        chk("pf_abort_lat", lat, 5);
        chk("pf_abort_data", d, line_of(28'h1));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
